// File: rtl/frac_lutk_arith_shadow_cfg.sv
// K-input fractional LUT / arith logic element with a shadow-buffered config chain.
// Datapath is combinational from the committed copy; config commits on the config_enable falling edge.
module frac_lutk_arith_shadow_cfg #(
  parameter int K         = 4,
  parameter int MODE_BITS = 2,
  parameter int CHAIN_W   = 1
) (
  input  logic               prog_clk,
  input  logic               pReset,
  input  logic               config_enable,
  input  logic [CHAIN_W-1:0] ccff_head,
  output logic [CHAIN_W-1:0] ccff_tail,
  input  logic [K-1:0]       frac_in,
  input  logic               cin,
  output logic [1:0]         lut_out,
  output logic               cout,
  output logic               cfg_valid,
  output logic               cfg_error
);

  localparam int TT = 1 << K;
  localparam int N  = TT + MODE_BITS;
  localparam int NS = N / CHAIN_W;
  localparam int CW = $clog2(NS + 1);
  localparam logic [CW-1:0] NS_C = CW'(NS);

  generate
    if (K < 3 || K > 6) begin : g_bad_k
      $error("frac_lutk_arith_shadow_cfg: K must be in 3..6");
    end
    if (MODE_BITS != 2) begin : g_bad_mode
      $error("frac_lutk_arith_shadow_cfg: MODE_BITS must be 2");
    end
    if ((N % CHAIN_W) != 0) begin : g_bad_chain
      $error("frac_lutk_arith_shadow_cfg: 2^K+MODE_BITS not divisible by CHAIN_W");
    end
  endgenerate

  logic [N-1:0]  sreg;
  logic [N-1:0]  sreg_nxt;
  logic [N-1:0]  act;
  logic [CW-1:0] cnt;
  logic          en_q;

  // New chunks enter at the top so the first-shifted chunk lands in sreg[CHAIN_W-1:0].
  generate
    if (CHAIN_W == N) begin : g_full
      assign sreg_nxt = ccff_head;
    end else begin : g_part
      assign sreg_nxt = {ccff_head, sreg[N-1:CHAIN_W]};
    end
  endgenerate

  assign ccff_tail = sreg[CHAIN_W-1:0];

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sreg      <= '0;
      act       <= '0;
      cnt       <= '0;
      en_q      <= 1'b0;
      cfg_valid <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      en_q <= config_enable;
      if (config_enable) begin
        sreg <= sreg_nxt;
        if (!en_q) begin
          cnt       <= CW'(1);
          cfg_error <= 1'b0;
        end else if (cnt != NS_C) begin
          cnt <= cnt + CW'(1);
        end
      end else if (en_q) begin
        // Commit only a complete stream; a short one leaves the active copy intact.
        if (cnt == NS_C) begin
          act       <= sreg;
          cfg_valid <= 1'b1;
        end else begin
          cfg_error <= 1'b1;
        end
      end
    end
  end

  logic [TT-1:0] tt;
  logic [1:0]    mode;
  logic [K-2:0]  idx;
  logic          lo_bit;
  logic          hi_bit;

  assign tt     = act[TT-1:0];
  assign mode   = act[TT+1:TT];
  assign idx    = frac_in[K-2:0];
  assign lo_bit = tt[{1'b0, idx}];
  assign hi_bit = tt[{1'b1, idx}];

  always_comb begin
    lut_out = 2'b00;
    cout    = 1'b0;
    case (mode)
      2'b00: lut_out[0] = tt[frac_in];
      2'b01: lut_out = {hi_bit, lo_bit};
      2'b10: begin
        // Lower half generates, upper half propagates.
        lut_out = {hi_bit, hi_bit ^ cin};
        cout    = hi_bit ? cin : lo_bit;
      end
      default: begin
        lut_out = 2'b00;
        cout    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_frac_lutk_arith_shadow_cfg.sv
// Directed, table-driven bench for frac_lutk_arith_shadow_cfg (K=4, CHAIN_W=1 and CHAIN_W=2 instances).
module tb_frac_lutk_arith_shadow_cfg;

  logic       prog_clk = 1'b0;
  logic       pReset;
  always #5 prog_clk = ~prog_clk;

  logic       a_en, a_cin, a_cout, a_valid, a_err;
  logic [0:0] a_head, a_tail;
  logic [3:0] a_frac;
  logic [1:0] a_lut;

  logic       b_en, b_cin, b_cout, b_valid, b_err;
  logic [1:0] b_head, b_tail;
  logic [3:0] b_frac;
  logic [1:0] b_lut;

  frac_lutk_arith_shadow_cfg #(.K(4), .MODE_BITS(2), .CHAIN_W(1)) dut_a (
    .prog_clk(prog_clk), .pReset(pReset), .config_enable(a_en),
    .ccff_head(a_head), .ccff_tail(a_tail), .frac_in(a_frac), .cin(a_cin),
    .lut_out(a_lut), .cout(a_cout), .cfg_valid(a_valid), .cfg_error(a_err)
  );

  frac_lutk_arith_shadow_cfg #(.K(4), .MODE_BITS(2), .CHAIN_W(2)) dut_b (
    .prog_clk(prog_clk), .pReset(pReset), .config_enable(b_en),
    .ccff_head(b_head), .ccff_tail(b_tail), .frac_in(b_frac), .cin(b_cin),
    .lut_out(b_lut), .cout(b_cout), .cfg_valid(b_valid), .cfg_error(b_err)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic load_a(input logic [17:0] cfg);
    a_en = 1'b1;
    for (int i = 0; i < 18; i++) begin
      a_head = cfg[i];
      tick();
    end
    a_en = 1'b0;
    tick();
  endtask

  task automatic load_b(input logic [17:0] cfg, input logic shadow, input logic [1:0] hold_lut);
    b_en = 1'b1;
    for (int j = 0; j < 9; j++) begin
      b_head = cfg[2*j +: 2];
      tick();
      if (shadow) check("b_shadow_lut", 32'(b_lut), 32'(hold_lut));
    end
    b_en = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [15:0] tt;
    logic [1:0]  mode;
    logic [3:0]  frac;
    logic        cin;
    logic [1:0]  exp_lut;
    logic        exp_cout;
  } vec_t;

  vec_t vt[15];

  initial begin
    logic [17:0] loaded;
    logic        have_cfg;
    logic [17:0] cfg;
    logic [17:0] str_a;
    logic [17:0] str_b;
    logic [35:0] stream;

    // single 0x6996
    vt[0]  = '{16'h6996, 2'b00, 4'b0111, 1'b0, 2'b01, 1'b0};
    vt[1]  = '{16'h6996, 2'b00, 4'b1111, 1'b0, 2'b00, 1'b0};
    vt[2]  = '{16'h6996, 2'b00, 4'b0000, 1'b1, 2'b00, 1'b0};
    vt[3]  = '{16'h6996, 2'b00, 4'b0001, 1'b0, 2'b01, 1'b0};
    // arith 0x6688: g = tt[idx], p = tt[8+idx]
    vt[4]  = '{16'h6688, 2'b10, 4'b0011, 1'b1, 2'b01, 1'b1};
    vt[5]  = '{16'h6688, 2'b10, 4'b0001, 1'b1, 2'b10, 1'b1};
    vt[6]  = '{16'h6688, 2'b10, 4'b0000, 1'b1, 2'b01, 1'b0};
    vt[7]  = '{16'h6688, 2'b10, 4'b0011, 1'b0, 2'b00, 1'b1};
    vt[8]  = '{16'h6688, 2'b10, 4'b0001, 1'b0, 2'b11, 1'b0};
    vt[9]  = '{16'h6688, 2'b10, 4'b1001, 1'b0, 2'b11, 1'b0};
    // dual 0xF00F
    vt[10] = '{16'hF00F, 2'b01, 4'b1000, 1'b1, 2'b01, 1'b0};
    vt[11] = '{16'hF00F, 2'b01, 4'b0100, 1'b0, 2'b10, 1'b0};
    vt[12] = '{16'hF00F, 2'b01, 4'b1100, 1'b0, 2'b10, 1'b0};
    // reserved
    vt[13] = '{16'hFFFF, 2'b11, 4'b0101, 1'b1, 2'b00, 1'b0};
    vt[14] = '{16'hFFFF, 2'b11, 4'b1111, 1'b0, 2'b00, 1'b0};

    a_en = 1'b0; a_head = '0; a_frac = '0; a_cin = 1'b0;
    b_en = 1'b0; b_head = '0; b_frac = '0; b_cin = 1'b0;

    // Reset with shifting requested and random chain data.
    pReset = 1'b1;
    a_en   = 1'b1;
    b_en   = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_head = 1'($urandom);
      b_head = 2'($urandom);
      tick();
    end
    a_frac = 4'b0000;
    check("rst_tail", 32'(a_tail), 0);
    check("rst_lut", 32'(a_lut), 0);
    check("rst_cout", 32'(a_cout), 0);
    check("rst_valid", 32'(a_valid), 0);
    check("rst_error", 32'(a_err), 0);
    check("rst_b_tail", 32'(b_tail), 0);
    pReset = 1'b0;
    a_en   = 1'b0;
    b_en   = 1'b0;
    tick();
    check("rst_no_commit_valid", 32'(a_valid), 0);
    check("rst_no_commit_error", 32'(a_err), 0);

    // Table: reload only when the configuration changes.
    have_cfg = 1'b0;
    loaded   = '0;
    for (int v = 0; v < 15; v++) begin
      cfg = {vt[v].mode, vt[v].tt};
      if (!have_cfg || cfg != loaded) begin
        load_a(cfg);
        check($sformatf("vec%0d_valid", v), 32'(a_valid), 1);
        loaded   = cfg;
        have_cfg = 1'b1;
      end
      a_frac = vt[v].frac;
      a_cin  = vt[v].cin;
      #1;
      check($sformatf("vec%0d_lut", v), 32'(a_lut), 32'(vt[v].exp_lut));
      check($sformatf("vec%0d_cout", v), 32'(a_cout), 32'(vt[v].exp_cout));
    end

    // Early drop keeps the committed 0x6996 single-mode config.
    load_a({2'b00, 16'h6996});
    a_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_head = 1'b1;
      tick();
    end
    a_en = 1'b0;
    tick();
    a_frac = 4'b0111; #1;
    check("early_error", 32'(a_err), 1);
    check("early_valid", 32'(a_valid), 1);
    check("early_lut7", 32'(a_lut), 2'b01);
    a_frac = 4'b1111; #1;
    check("early_lut15", 32'(a_lut), 2'b00);

    // Pass-through: A then B back-to-back; first shift edge is also the rising edge.
    str_a  = {2'b10, 16'h1234};
    str_b  = {2'b00, 16'hA5C3};
    stream = {str_b, str_a};
    a_frac = 4'b0111;
    a_en   = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      a_head = stream[k-1];
      tick();
      if (k == 1) check("rise_clears_error", 32'(a_err), 0);
      if (k >= 18 && k <= 35) check($sformatf("tail_k%0d", k), 32'(a_tail), 32'(str_a[k-18]));
      check($sformatf("pt_shadow_k%0d", k), 32'(a_lut), 2'b01);
    end
    check("tail_k36", 32'(a_tail), 32'(str_b[0]));
    a_en = 1'b0;
    tick();
    check("pt_valid", 32'(a_valid), 1);
    check("pt_error", 32'(a_err), 0);
    a_frac = 4'b0000; #1;
    check("pt_b_lut0", 32'(a_lut), 2'b01);
    a_frac = 4'b0010; #1;
    check("pt_b_lut2", 32'(a_lut), 2'b00);
    a_frac = 4'b1111; #1;
    check("pt_b_lut15", 32'(a_lut), 2'b01);

    // CHAIN_W=2: base config then dual 0xF00F with shadow check on every shift.
    load_b({2'b00, 16'hFFFF}, 1'b0, 2'b00);
    check("b_valid", 32'(b_valid), 1);
    b_frac = 4'b0100; #1;
    check("b_base_lut", 32'(b_lut), 2'b01);
    load_b({2'b01, 16'hF00F}, 1'b1, 2'b01);
    check("b_dual_valid", 32'(b_valid), 1);
    check("b_dual_error", 32'(b_err), 0);
    check("b_tail", 32'(b_tail), 2'b11);
    b_frac = 4'b1000; #1;
    check("b_dual_1000", 32'(b_lut), 2'b01);
    check("b_dual_cout", 32'(b_cout), 0);
    b_frac = 4'b0100; #1;
    check("b_dual_0100", 32'(b_lut), 2'b10);

    // Reset mid-shift discards the stream; no commit follows.
    a_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_head = 1'b1;
      tick();
    end
    pReset = 1'b1;
    tick();
    pReset = 1'b0;
    a_en   = 1'b0;
    tick();
    a_frac = 4'b0000; #1;
    check("midrst_valid", 32'(a_valid), 0);
    check("midrst_error", 32'(a_err), 0);
    check("midrst_lut", 32'(a_lut), 0);
    check("midrst_tail", 32'(a_tail), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
